// File: rtl/control_unit_mc_pkg.sv
// cu_pkg: opcodes, ALU/M operation codes, control-word struct and sequencer state for control_unit_mc
package cu_pkg;
  localparam int ALU_W = 5;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  // M ops occupy 16..23 so the code is {2'b10, funct3}
  typedef enum logic [ALU_W-1:0] {
    ALU_ADD = 5'd0, ALU_SUB = 5'd1, ALU_SLL = 5'd2, ALU_SLT = 5'd3,
    ALU_SLTU = 5'd4, ALU_XOR = 5'd5, ALU_SRL = 5'd6, ALU_SRA = 5'd7,
    ALU_OR = 5'd8, ALU_AND = 5'd9, ALU_LUI = 5'd10,
    ALU_MUL = 5'd16, ALU_MULH = 5'd17, ALU_MULHSU = 5'd18, ALU_MULHU = 5'd19,
    ALU_DIV = 5'd20, ALU_DIVU = 5'd21, ALU_REM = 5'd22, ALU_REMU = 5'd23
  } alu_ctrl_e;
  typedef enum logic [1:0] {RES_ALU, RES_MEM, RES_PC4} result_src_t;
  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_src_t;
  typedef enum logic [1:0] {LAT_ONE, LAT_MUL, LAT_DIV} lat_t;
  typedef enum logic {RUN, MD_BUSY} md_state_t;
  // all-zero value is the pipeline bubble
  typedef struct packed {
    logic        jump;
    logic        branch;
    logic        jalr;
    logic [2:0]  funct3;
    result_src_t result_src;
    logic        mem_write;
    logic        alu_src;
    alu_ctrl_e   alu_ctrl;
    logic        reg_write;
    logic        illegal;
  } ctrl_t;
  // base integer op from funct3; alt selects sub/sra
  function automatic alu_ctrl_e alu_base(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/control_unit_mc_if.sv
// control_unit_mc_if: D-stage instruction, hazard handshake and E-stage control outputs
//   master: instruction/hazard side (drives ins, ins_valid, stall_in, flush_in)
//   slave : control unit (drives decode, E-stage and sequencer outputs)
interface control_unit_mc_if #(
  parameter int WIDTH = 32,
  parameter int ALU_CTRL_W = 5
);
  logic [WIDTH-1:0]      ins;
  logic                  ins_valid;
  logic                  stall_in;
  logic                  flush_in;
  logic [2:0]            imm_src_d;
  logic                  rs1_used_d;
  logic                  rs2_used_d;
  logic                  jump_e;
  logic                  branch_e;
  logic                  jalr_e;
  logic [2:0]            funct3_e;
  logic [1:0]            result_src_e;
  logic                  mem_write_e;
  logic                  alu_src_e;
  logic [ALU_CTRL_W-1:0] alu_ctrl_e;
  logic                  reg_write_e;
  logic                  illegal_e;
  logic                  md_busy;
  logic                  stall_req;
  modport master (
    output ins, ins_valid, stall_in, flush_in,
    input  imm_src_d, rs1_used_d, rs2_used_d, jump_e, branch_e, jalr_e, funct3_e,
           result_src_e, mem_write_e, alu_src_e, alu_ctrl_e, reg_write_e, illegal_e,
           md_busy, stall_req
  );
  modport slave (
    input  ins, ins_valid, stall_in, flush_in,
    output imm_src_d, rs1_used_d, rs2_used_d, jump_e, branch_e, jalr_e, funct3_e,
           result_src_e, mem_write_e, alu_src_e, alu_ctrl_e, reg_write_e, illegal_e,
           md_busy, stall_req
  );
endinterface

// File: rtl/control_unit_mc_decode.sv
// cu_decode: combinational RV32I(+M) decode to a control word
//   i_op/i_f3/i_f7: instruction fields, i_valid: not a bubble
//   o_ctrl: control word (zero when !i_valid), o_imm_src/o_rs*_used: D-stage hazard info
//   o_lat (M_EXT_EN only): latency class of the op
module cu_decode
  import cu_pkg::*;
(
  input  logic [6:0] i_op,
  input  logic [2:0] i_f3,
  input  logic [6:0] i_f7,
  input  logic       i_valid,
  output ctrl_t      o_ctrl,
  output imm_src_t   o_imm_src,
  output logic       o_rs1_used,
  output logic       o_rs2_used
`ifdef M_EXT_EN
  ,
  output lat_t       o_lat
`endif
);
  logic w_ok;
  always_comb begin
    o_ctrl = '0;
    o_imm_src = IMM_I;
    o_rs1_used = 1'b0;
    o_rs2_used = 1'b0;
`ifdef M_EXT_EN
    o_lat = LAT_ONE;
`endif
    w_ok = 1'b1;
    case (i_op)
      OP_R: begin
        o_ctrl.funct3 = i_f3;
        o_ctrl.reg_write = 1'b1;
        o_rs1_used = 1'b1;
        o_rs2_used = 1'b1;
        o_ctrl.alu_ctrl = alu_base(i_f3, i_f7[5]);
        if (i_f7 == 7'b0100000) w_ok = i_f3 == 3'b000 || i_f3 == 3'b101;
`ifdef M_EXT_EN
        else if (i_f7 == 7'b0000001) begin
          o_ctrl.alu_ctrl = alu_ctrl_e'({2'b10, i_f3});
          o_lat = i_f3[2] ? LAT_DIV : LAT_MUL;
        end
`endif
        else w_ok = i_f7 == 7'b0;
      end
      OP_IMM: begin
        o_ctrl.funct3 = i_f3;
        o_ctrl.alu_src = 1'b1;
        o_ctrl.reg_write = 1'b1;
        o_rs1_used = 1'b1;
        o_ctrl.alu_ctrl = alu_base(i_f3, i_f3 == 3'b101 && i_f7[5]);
        w_ok = i_f3 == 3'b001 ? i_f7 == 7'b0 :
               i_f3 == 3'b101 ? (i_f7 & 7'b1011111) == 7'b0 : 1'b1;
      end
      OP_LOAD: begin
        o_ctrl.funct3 = i_f3;
        o_ctrl.result_src = RES_MEM;
        o_ctrl.alu_src = 1'b1;
        o_ctrl.reg_write = 1'b1;
        o_rs1_used = 1'b1;
        w_ok = !(i_f3 == 3'b011 || i_f3[2:1] == 2'b11);
      end
      OP_STORE: begin
        o_ctrl.funct3 = i_f3;
        o_ctrl.mem_write = 1'b1;
        o_ctrl.alu_src = 1'b1;
        o_imm_src = IMM_S;
        o_rs1_used = 1'b1;
        o_rs2_used = 1'b1;
        w_ok = i_f3 < 3'b011;
      end
      OP_BRANCH: begin
        o_ctrl.funct3 = i_f3;
        o_ctrl.branch = 1'b1;
        o_ctrl.alu_ctrl = ALU_SUB;
        o_imm_src = IMM_B;
        o_rs1_used = 1'b1;
        o_rs2_used = 1'b1;
        w_ok = i_f3[2:1] != 2'b01;
      end
      OP_JAL: begin
        o_ctrl.jump = 1'b1;
        o_ctrl.result_src = RES_PC4;
        o_ctrl.reg_write = 1'b1;
        o_imm_src = IMM_J;
      end
      OP_JALR: begin
        o_ctrl.funct3 = i_f3;
        o_ctrl.jump = 1'b1;
        o_ctrl.jalr = 1'b1;
        o_ctrl.result_src = RES_PC4;
        o_ctrl.alu_src = 1'b1;
        o_ctrl.reg_write = 1'b1;
        o_rs1_used = 1'b1;
        w_ok = i_f3 == 3'b000;
      end
      OP_LUI: begin
        o_ctrl.alu_src = 1'b1;
        o_ctrl.alu_ctrl = ALU_LUI;
        o_ctrl.reg_write = 1'b1;
        o_imm_src = IMM_U;
      end
      OP_AUIPC: begin
        o_ctrl.alu_src = 1'b1;
        o_ctrl.reg_write = 1'b1;
        o_imm_src = IMM_U;
      end
      default: w_ok = 1'b0;
    endcase
    // bubbles and illegal ops carry no side effects and read no registers
    if (!w_ok || !i_valid) begin
      o_ctrl = '0;
      o_ctrl.illegal = i_valid;
      o_imm_src = IMM_I;
      o_rs1_used = 1'b0;
      o_rs2_used = 1'b0;
`ifdef M_EXT_EN
      o_lat = LAT_ONE;
`endif
    end
  end
endmodule

// File: rtl/control_unit_mc.sv
// control_unit_mc: RV32 decode with D/E control register and multi-cycle M-op sequencer
//   clk, rst_n (async, active low)
//   cu (slave): ins/ins_valid/stall_in/flush_in in; decode, E-stage, md_busy, stall_req out
//   Macro M_EXT_EN: enables M decode and the MD_BUSY sequencer (MUL_CYCLES/DIV_CYCLES)
module control_unit_mc
  import cu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ALU_CTRL_W = 5
`ifdef M_EXT_EN
  ,
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 8
`endif
) (
  input logic clk,
  input logic rst_n,
  control_unit_mc_if.slave cu
);
  ctrl_t    w_ctrl;
  ctrl_t    r_ctrl;
  imm_src_t w_imm;
  logic     w_rs1_used;
  logic     w_rs2_used;
  logic     w_stall_req;
`ifdef M_EXT_EN
  lat_t       w_lat;
  logic [3:0] w_len;
  logic [3:0] r_cnt;
  md_state_t  r_state;
`endif
  cu_decode u_decode (
    .i_op      (cu.ins[6:0]),
    .i_f3      (cu.ins[14:12]),
    .i_f7      (cu.ins[WIDTH-1 -: 7]),
    .i_valid   (cu.ins_valid),
    .o_ctrl    (w_ctrl),
    .o_imm_src (w_imm),
    .o_rs1_used(w_rs1_used),
    .o_rs2_used(w_rs2_used)
`ifdef M_EXT_EN
    ,
    .o_lat     (w_lat)
`endif
  );
`ifdef M_EXT_EN
  assign w_len = w_lat == LAT_DIV ? 4'(DIV_CYCLES) : w_lat == LAT_MUL ? 4'(MUL_CYCLES) : 4'd1;
  assign w_stall_req = r_state == MD_BUSY && r_cnt != 4'd0;
  // a counting M op holds E regardless of stall_in; at cnt==0 the state
  // behaves like RUN, so the next op (possibly another M op) loads directly
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= RUN;
      r_cnt <= '0;
      r_ctrl <= '0;
    end else if (cu.flush_in) begin
      r_state <= RUN;
      r_cnt <= '0;
      r_ctrl <= '0;
    end else if (w_stall_req) begin
      r_cnt <= r_cnt - 4'd1;
    end else if (!cu.stall_in) begin
      r_ctrl <= w_ctrl;
      r_state <= w_len > 4'd1 ? MD_BUSY : RUN;
      r_cnt <= w_len - 4'd1;
    end
  assign cu.md_busy = r_state == MD_BUSY;
`else
  assign w_stall_req = 1'b0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_ctrl <= '0;
    else if (cu.flush_in) r_ctrl <= '0;
    else if (!cu.stall_in) r_ctrl <= w_ctrl;
  assign cu.md_busy = 1'b0;
`endif
  assign cu.stall_req = w_stall_req;
  assign cu.imm_src_d = w_imm;
  assign cu.rs1_used_d = w_rs1_used;
  assign cu.rs2_used_d = w_rs2_used;
  assign cu.jump_e = r_ctrl.jump;
  assign cu.branch_e = r_ctrl.branch;
  assign cu.jalr_e = r_ctrl.jalr;
  assign cu.funct3_e = r_ctrl.funct3;
  assign cu.result_src_e = r_ctrl.result_src;
  assign cu.mem_write_e = r_ctrl.mem_write;
  assign cu.alu_src_e = r_ctrl.alu_src;
  assign cu.alu_ctrl_e = ALU_CTRL_W'(r_ctrl.alu_ctrl);
  // write-back only in the final occupancy cycle of an M op
  assign cu.reg_write_e = r_ctrl.reg_write && !w_stall_req;
  assign cu.illegal_e = r_ctrl.illegal;
endmodule

// File: tb/tb_control_unit_mc.sv
// tb_control_unit_mc: scoreboard bench for control_unit_mc (default and M_EXT_EN builds)
module tb_control_unit_mc;
  typedef struct packed {
    logic       j, b, jr;
    logic [2:0] f3;
    logic [1:0] res;
    logic       mw, asrc;
    logic [4:0] alu;
    logic       rw, il, bz, sr;
  } e_t;
  function automatic e_t ew(input logic j, b, jr, input logic [2:0] f3, input logic [1:0] res,
                            input logic mw, asrc, input logic [4:0] alu, input logic rw, il, bz, sr);
    return {j, b, jr, f3, res, mw, asrc, alu, rw, il, bz, sr};
  endfunction
  localparam logic [31:0] ADD  = 32'h002081B3;
  localparam logic [31:0] SUB  = 32'h402081B3;
  localparam logic [31:0] LW   = 32'h0080A283;
  localparam logic [31:0] SW   = 32'h00512223;
  localparam logic [31:0] BEQ  = 32'h00208463;
  localparam logic [31:0] JAL  = 32'h010000EF;
  localparam logic [31:0] JALR = 32'h00008067;
  localparam logic [31:0] LUI  = 32'h123452B7;
  localparam logic [31:0] ADDI = 32'hFFF00093;
  localparam logic [31:0] SRAI = 32'h4030D093;
  localparam logic [31:0] BADS = 32'h40109093;
  localparam logic [31:0] OP7F = 32'h0000007F;
  localparam logic [31:0] MUL  = 32'h023100B3;
  localparam logic [31:0] DIV  = 32'h0220C233;
  localparam logic [4:0] D_Z = 5'b000_00, D_RR = 5'b000_11, D_I = 5'b000_10, D_S = 5'b001_11;
  localparam logic [4:0] D_B = 5'b010_11, D_U = 5'b011_00, D_J = 5'b100_00;
  localparam e_t E_Z    = '0;
  localparam e_t E_ADD  = ew(0, 0, 0, 3'd0, 2'd0, 0, 0, 5'd0, 1, 0, 0, 0);
  localparam e_t E_SUB  = ew(0, 0, 0, 3'd0, 2'd0, 0, 0, 5'd1, 1, 0, 0, 0);
  localparam e_t E_LW   = ew(0, 0, 0, 3'd2, 2'd1, 0, 1, 5'd0, 1, 0, 0, 0);
  localparam e_t E_SW   = ew(0, 0, 0, 3'd2, 2'd0, 1, 1, 5'd0, 0, 0, 0, 0);
  localparam e_t E_BEQ  = ew(0, 1, 0, 3'd0, 2'd0, 0, 0, 5'd1, 0, 0, 0, 0);
  localparam e_t E_JAL  = ew(1, 0, 0, 3'd0, 2'd2, 0, 0, 5'd0, 1, 0, 0, 0);
  localparam e_t E_JALR = ew(1, 0, 1, 3'd0, 2'd2, 0, 1, 5'd0, 1, 0, 0, 0);
  localparam e_t E_LUI  = ew(0, 0, 0, 3'd0, 2'd0, 0, 1, 5'd10, 1, 0, 0, 0);
  localparam e_t E_ADDI = ew(0, 0, 0, 3'd0, 2'd0, 0, 1, 5'd0, 1, 0, 0, 0);
  localparam e_t E_SRAI = ew(0, 0, 0, 3'd5, 2'd0, 0, 1, 5'd7, 1, 0, 0, 0);
  localparam e_t E_ILL  = ew(0, 0, 0, 3'd0, 2'd0, 0, 0, 5'd0, 0, 1, 0, 0);
`ifdef M_EXT_EN
  localparam e_t E_MUL0 = ew(0, 0, 0, 3'd0, 2'd0, 0, 0, 5'd16, 0, 0, 1, 1);
  localparam e_t E_MUL1 = ew(0, 0, 0, 3'd0, 2'd0, 0, 0, 5'd16, 1, 0, 1, 0);
  localparam e_t E_DIV0 = ew(0, 0, 0, 3'd4, 2'd0, 0, 0, 5'd20, 0, 0, 1, 1);
  localparam e_t E_DIV8 = ew(0, 0, 0, 3'd4, 2'd0, 0, 0, 5'd20, 1, 0, 1, 0);
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_pass = 0;
  e_t sb[$];
  control_unit_mc_if #(.WIDTH(32), .ALU_CTRL_W(5)) bus ();
  control_unit_mc dut (.clk(clk), .rst_n(rst_n), .cu(bus));
  always #5 clk = ~clk;
  function automatic e_t obs();
    return {bus.jump_e, bus.branch_e, bus.jalr_e, bus.funct3_e, bus.result_src_e, bus.mem_write_e,
            bus.alu_src_e, bus.alu_ctrl_e, bus.reg_write_e, bus.illegal_e, bus.md_busy, bus.stall_req};
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic step(input string tag, input logic [31:0] ins, input logic v, st, fl,
                      input logic [4:0] d_exp, input e_t e_exp);
    @(negedge clk);
    bus.ins = ins;
    bus.ins_valid = v;
    bus.stall_in = st;
    bus.flush_in = fl;
    #1 check({tag, "/d"}, 32'({bus.imm_src_d, bus.rs1_used_d, bus.rs2_used_d}), 32'(d_exp));
    sb.push_back(e_exp);
    @(posedge clk);
    #1 check({tag, "/e"}, 32'(obs()), 32'(sb.pop_front()));
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.ins = '0;
    bus.ins_valid = 1'b0;
    bus.stall_in = 1'b0;
    bus.flush_in = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_hold", 32'(obs()), 32'(E_Z));
    rst_n = 1'b1;
    step("add", ADD, 1, 0, 0, D_RR, E_ADD);
    @(negedge clk);
    rst_n = 1'b0;
    #1 check("rst_async", 32'(obs()), 32'(E_Z));
    @(negedge clk);
    rst_n = 1'b1;
    step("add_r", ADD, 1, 0, 0, D_RR, E_ADD);
    step("lw", LW, 1, 0, 0, D_I, E_LW);
    step("sw", SW, 1, 0, 0, D_S, E_SW);
    step("beq", BEQ, 1, 0, 0, D_B, E_BEQ);
    step("jal", JAL, 1, 0, 0, D_J, E_JAL);
    step("jalr", JALR, 1, 0, 0, D_I, E_JALR);
    step("lui", LUI, 1, 0, 0, D_U, E_LUI);
    step("addi", ADDI, 1, 0, 0, D_I, E_ADDI);
    step("srai", SRAI, 1, 0, 0, D_I, E_SRAI);
    step("sub", SUB, 1, 0, 0, D_RR, E_SUB);
    step("stall1", SW, 1, 1, 0, D_S, E_SUB);
    step("stall2", SW, 1, 1, 0, D_S, E_SUB);
    step("unstall", SW, 1, 0, 0, D_S, E_SW);
    step("flush", LW, 1, 0, 1, D_I, E_Z);
    step("lw2", LW, 1, 0, 0, D_I, E_LW);
    step("fl_st", ADD, 1, 1, 1, D_RR, E_Z);
    step("bubble", LW, 0, 0, 0, D_Z, E_Z);
    step("ill7f", OP7F, 1, 0, 0, D_Z, E_ILL);
    step("ill_slli", BADS, 1, 0, 0, D_Z, E_ILL);
    step("after_ill", ADD, 1, 0, 0, D_RR, E_ADD);
`ifdef M_EXT_EN
    step("mul1", MUL, 1, 0, 0, D_RR, E_MUL0);
    step("mul2", ADD, 1, 0, 0, D_RR, E_MUL1);
    step("mul_nx", ADD, 1, 0, 0, D_RR, E_ADD);
    step("div1", DIV, 1, 0, 0, D_RR, E_DIV0);
    for (int i = 2; i <= 7; i++) step($sformatf("div%0d", i), ADD, 1, 0, 0, D_RR, E_DIV0);
    step("div8", ADD, 1, 0, 0, D_RR, E_DIV8);
    step("div_nx", ADD, 1, 0, 0, D_RR, E_ADD);
    step("dfl1", DIV, 1, 0, 0, D_RR, E_DIV0);
    step("dfl2", ADD, 1, 0, 0, D_RR, E_DIV0);
    step("dfl3", ADD, 1, 0, 0, D_RR, E_DIV0);
    step("dfl4", ADD, 1, 0, 1, D_RR, E_Z);
    step("dfl_nx", ADD, 1, 0, 0, D_RR, E_ADD);
    step("dst1", DIV, 1, 0, 0, D_RR, E_DIV0);
    for (int i = 2; i <= 7; i++) step($sformatf("dst%0d", i), ADD, 1, 0, 0, D_RR, E_DIV0);
    for (int i = 8; i <= 11; i++) step($sformatf("dst%0d", i), ADD, 1, 1, 0, D_RR, E_DIV8);
    step("dst_flst", ADD, 1, 1, 1, D_RR, E_Z);
    step("dst_nx", ADD, 1, 0, 0, D_RR, E_ADD);
    step("drst", DIV, 1, 0, 0, D_RR, E_DIV0);
    @(negedge clk);
    rst_n = 1'b0;
    #1 check("drst_async", 32'(obs()), 32'(E_Z));
    @(negedge clk);
    rst_n = 1'b1;
    step("drst_nx", ADD, 1, 0, 0, D_RR, E_ADD);
`else
    step("mul_nom", MUL, 1, 0, 0, D_Z, E_ILL);
    step("div_nom", DIV, 1, 0, 0, D_Z, E_ILL);
    step("nom_nx", ADD, 1, 0, 0, D_RR, E_ADD);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
